lms_ctr_oc_mem_arb: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port 8192×32 on-chip memory of the lms_ctr subsystem between two masters: CPU data master on port s0, DMA/host-bridge master on port s1. Grants at most one transfer per cycle to the memory port, using round-robin with a bounded hold window. Returns read data with fixed one-cycle latency via readdatavalid. Sits between the interconnect and the memory's s1 port; the memory's clken is tied high and reset_req tied low at integration.

---
 rtl/lms_ctr_oc_mem_pkg.sv | 20 ++
 rtl/lms_ctr_rr_hold_arb.sv | 37 +++
 rtl/lms_ctr_oc_mem_arb.sv | 84 ++++++++
 tb/tb_lms_ctr_oc_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_ctr_oc_mem_pkg.sv
// Shared definitions for the lms_ctr on-chip memory and the logic that arbitrates access to it.
package lms_ctr_oc_mem_pkg;
  localparam int OC_MEM_ADDR_W = 13;
  localparam int OC_MEM_DATA_W = 32;
  localparam int OC_MEM_BE_W   = 4;
  localparam int NUM_PORTS     = 2;

  typedef logic port_idx_t;

  typedef struct packed {
    logic [OC_MEM_ADDR_W-1:0] address;
    logic [OC_MEM_BE_W-1:0]   byteenable;
    logic                     write;
    logic [OC_MEM_DATA_W-1:0] writedata;
  } oc_mem_req_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/lms_ctr_rr_hold_arb.sv
// Two-way round-robin arbiter: the current owner keeps winning ties until it has
// held the grant for HOLD_MAX consecutive grants, then the other port gets it.
module lms_ctr_rr_hold_arb
  import lms_ctr_oc_mem_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  // Owner is one-hot; resetting it to s0 makes s0 win the first tie.
  logic [NUM_PORTS-1:0] owner;
  logic [3:0]           hold_cnt;

  always_comb begin
    gnt = req;
    if (&req) gnt = (hold_cnt < HOLD_LIM) ? owner : ~owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 2'b01;
      hold_cnt <= '0;
    end else if (|gnt) begin
      if (gnt == owner) begin
        hold_cnt <= sat_inc4(hold_cnt);
      end else begin
        owner    <= gnt;
        hold_cnt <= 4'd1;
      end
    end
  end
endmodule

// File: rtl/lms_ctr_oc_mem_arb.sv
// Shares the single-port on-chip memory between the CPU (s0) and DMA (s1) masters,
// one transfer per cycle, with a one-cycle read return steered to the accepting port.
module lms_ctr_oc_mem_arb
  import lms_ctr_oc_mem_pkg::*;
#(
  parameter int ADDR_W   = OC_MEM_ADDR_W,
  parameter int DATA_W   = OC_MEM_DATA_W,
  parameter int BE_W     = OC_MEM_BE_W,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);
  oc_mem_req_t [NUM_PORTS-1:0] preq;
  logic [NUM_PORTS-1:0] req, rd_req, gnt, wait_v, rdv_v;
  port_idx_t            gsel;
  logic                 rd_pend;
  port_idx_t            rd_port;

  assign preq[0] = {s0_address, s0_byteenable, s0_write, s0_writedata};
  assign preq[1] = {s1_address, s1_byteenable, s1_write, s1_writedata};
  assign req     = {s1_read | s1_write, s0_read | s0_write};
  // Read+write together is a write; only pure reads produce a return.
  assign rd_req  = {s1_read & ~s1_write, s0_read & ~s0_write};

  lms_ctr_rr_hold_arb #(.HOLD_MAX(HOLD_MAX)) u_arb (
    .clk (clk),
    .rst (reset),
    .req (req),
    .gnt (gnt)
  );

  // With no grant the select falls to s0, so the bus idles on s0's fields.
  assign gsel           = gnt[1];
  assign mem_address    = preq[gsel].address;
  assign mem_byteenable = preq[gsel].byteenable;
  assign mem_writedata  = preq[gsel].writedata;
  assign mem_chipselect = |gnt;
  assign mem_write      = (|gnt) & preq[gsel].write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      rd_pend <= (|gnt) & rd_req[gsel];
      if (|gnt) rd_port <= gsel;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign wait_v[p] = ~gnt[p];
    assign rdv_v[p]  = rd_pend & (rd_port == port_idx_t'(p));
  end

  assign s0_waitrequest   = wait_v[0];
  assign s1_waitrequest   = wait_v[1];
  assign s0_readdatavalid = rdv_v[0];
  assign s1_readdatavalid = rdv_v[1];
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;
endmodule

// File: tb/tb_lms_ctr_oc_mem_arb.sv
// Bench for lms_ctr_oc_mem_arb: a behavioural RAM stands in for the memory, and a
// rule-level model (owner/hold counts, shadow memory) predicts every cycle.
module tb_lms_ctr_oc_mem_arb;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rd, wr;
  logic [12:0] ad [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic [31:0] s0_readdata, s1_readdata, mem_readdata, mem_writedata;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lms_ctr_oc_mem_arb #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset),
    .s0_address(ad[0]), .s0_byteenable(be[0]), .s0_read(rd[0]), .s0_write(wr[0]),
    .s0_writedata(wd[0]), .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(ad[1]), .s1_byteenable(be[1]), .s1_read(rd[1]), .s1_write(wr[1]),
    .s1_writedata(wd[1]), .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Memory device: registered read, byte-lane writes, never reset.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  // Reference model state.
  logic [31:0]  ref_mem [0:8191];
  int           m_owner, m_hold, m_pend, m_g;
  logic [31:0]  m_pend_data;
  logic [118:0] exp_obs, obs;

  assign obs = {s1_waitrequest, s0_waitrequest, mem_chipselect, mem_write,
                s1_readdatavalid, s0_readdatavalid,
                mem_address, mem_byteenable, mem_writedata,
                (s0_readdatavalid | s1_readdatavalid) ? {s0_readdata, s1_readdata} : 64'h0};

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic idle();
    rd = 2'b00; wr = 2'b00;
    for (int p = 0; p < 2; p++) begin ad[p] = '0; be[p] = '0; wd[p] = '0; end
  endtask

  task automatic model_eval();
    bit r0, r1;
    int p;
    r0 = rd[0] | wr[0];
    r1 = rd[1] | wr[1];
    if (r0 && r1)  m_g = (m_hold < HOLD) ? m_owner : 1 - m_owner;
    else if (r0)   m_g = 0;
    else if (r1)   m_g = 1;
    else           m_g = -1;
    p = (m_g < 0) ? 0 : m_g;
    exp_obs = {m_g != 1, m_g != 0, m_g >= 0, (m_g >= 0) && wr[p], m_pend == 1, m_pend == 0,
               ad[p], be[p], wd[p], (m_pend >= 0) ? {m_pend_data, m_pend_data} : 64'h0};
  endtask

  task automatic model_commit();
    m_pend = -1;
    if (m_g >= 0) begin
      if (wr[m_g]) begin
        for (int b = 0; b < 4; b++)
          if (be[m_g][b]) ref_mem[ad[m_g]][8*b +: 8] = wd[m_g][8*b +: 8];
      end else begin
        m_pend      = m_g;
        m_pend_data = ref_mem[ad[m_g]];
      end
      if (m_g == m_owner) m_hold = (m_hold < 15) ? m_hold + 1 : 15;
      else begin m_owner = m_g; m_hold = 1; end
    end
  endtask

  task automatic next_edge();
    model_commit();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_owner = 0; m_hold = 0; m_pend = -1; m_g = -1;
  endtask

  task automatic apply_reset();
    idle(); reset = 1'b1; model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; model_reset();
    @(negedge clk); n_cmp++;
    if (obs[118:113] !== 6'b110000)
      begin n_err++; $display("FAIL reset_ctl act=%b exp=%b", obs[118:113], 6'b110000); end
    apply_reset();
    model_eval();
    @(negedge clk); n_cmp++;
    if (obs !== exp_obs) begin n_err++; $display("FAIL reset_idle act=%h exp=%h", obs, exp_obs); end
    next_edge();
  endtask

  task automatic test_tie_read();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      ad[0] = 13'h0010; ad[1] = 13'h0010;
      if (c == 0) rd = 2'b11;
      if (c == 1) rd = 2'b10;
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL tie_read c=%0d act=%h exp=%h", c, obs, exp_obs); end
      if (c == 0) begin
        n_cmp++;
        if ({s1_waitrequest, s0_waitrequest} !== 2'b10)
          begin n_err++; $display("FAIL tie_first_gnt act=%b exp=10", {s1_waitrequest, s0_waitrequest}); end
      end
      next_edge();
    end
  endtask

  task automatic test_write_be();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) begin wr[0] = 1'b1; ad[0] = 13'h1FFF; wd[0] = 32'hDEADBEEF; be[0] = 4'b0101; end
      if (c == 1) begin rd[1] = 1'b1; ad[1] = 13'h1FFF; end
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL write_be c=%0d act=%h exp=%h", c, obs, exp_obs); end
      if (c == 2) begin
        n_cmp++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h00AD00EF)
          begin n_err++; $display("FAIL write_be_data act=%b/%h exp=1/00ad00ef", s1_readdatavalid, s1_readdata); end
      end
      next_edge();
    end
  endtask

  task automatic test_fairness();
    int w0 = 0, w1 = 0, wmax = 0;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      rd = 2'b10; wr = 2'b01;
      ad[0] = 13'h200 + 13'($urandom_range(0, 31)); wd[0] = $urandom; be[0] = 4'($urandom);
      ad[1] = 13'h200 + 13'($urandom_range(0, 31)); wd[1] = $urandom; be[1] = 4'($urandom);
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL fairness c=%0d act=%h exp=%h", c, obs, exp_obs); end
      n_cmp++;
      if (s0_waitrequest !== 1'((c / HOLD) % 2))
        begin n_err++; $display("FAIL fair_pattern c=%0d s0_wait act=%b exp=%0d", c, s0_waitrequest, (c / HOLD) % 2); end
      w0 = s0_waitrequest ? w0 + 1 : 0;
      w1 = s1_waitrequest ? w1 + 1 : 0;
      if (w0 > wmax) wmax = w0;
      if (w1 > wmax) wmax = w1;
      next_edge();
    end
    n_cmp++;
    if (wmax > HOLD) begin n_err++; $display("FAIL fair_max_wait act=%0d exp<=%0d", wmax, HOLD); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, vld = 0;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c < 8) begin rd[1] = 1'b1; ad[1] = 13'(c); end
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL b2b c=%0d act=%h exp=%h", c, obs, exp_obs); end
      if (!s1_waitrequest) acc++;
      if (s1_readdatavalid) begin
        vld++; n_cmp++;
        if (s1_readdata !== pre(c - 1))
          begin n_err++; $display("FAIL b2b_data c=%0d act=%h exp=%h", c, s1_readdata, pre(c - 1)); end
      end
      next_edge();
    end
    n_cmp++;
    if (acc != 8 || vld != 8) begin n_err++; $display("FAIL b2b_count acc=%0d vld=%0d exp=8/8", acc, vld); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    idle(); rd[0] = 1'b1; ad[0] = 13'h3; model_eval();
    @(negedge clk); n_cmp++;
    if (obs !== exp_obs) begin n_err++; $display("FAIL midrst_accept act=%h exp=%h", obs, exp_obs); end
    next_edge();
    idle(); reset = 1'b1; #1; model_reset(); model_eval();
    @(negedge clk); n_cmp++;
    if (s0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL midrst_rdv act=%b exp=0", s0_readdatavalid); end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      ad[0] = 13'h4; ad[1] = 13'h5;
      if (c == 0) rd = 2'b11;
      if (c == 1) rd = 2'b10;
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL midrst_tie c=%0d act=%h exp=%h", c, obs, exp_obs); end
      if (c == 0) begin
        n_cmp++;
        if ({s1_waitrequest, s0_waitrequest} !== 2'b10)
          begin n_err++; $display("FAIL midrst_gnt act=%b exp=10", {s1_waitrequest, s0_waitrequest}); end
      end
      next_edge();
    end
  endtask

  task automatic test_rw_both();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      ad[0] = 13'h0100;
      if (c == 0) begin rd[0] = 1'b1; wr[0] = 1'b1; wd[0] = 32'h12345678; be[0] = 4'hF; end
      if (c == 2) rd[0] = 1'b1;
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL rw_both c=%0d act=%h exp=%h", c, obs, exp_obs); end
      if (c == 1) begin
        n_cmp++;
        if (s0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rw_both_rdv act=%b exp=0", s0_readdatavalid); end
      end
      if (c == 3) begin
        n_cmp++;
        if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'h12345678)
          begin n_err++; $display("FAIL rw_both_data act=%b/%h exp=1/12345678", s0_readdatavalid, s0_readdata); end
      end
      next_edge();
    end
  endtask

  task automatic test_random();
    bit [1:0] busy = 2'b00;
    int k;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            busy[p] = 1'b1;
            k = $urandom_range(0, 3);
            rd[p] = (k != 2); wr[p] = (k >= 2);
            ad[p] = 13'($urandom_range(0, 23)); be[p] = 4'($urandom); wd[p] = $urandom;
          end else begin
            rd[p] = 1'b0; wr[p] = 1'b0;
          end
        end
      end
      model_eval();
      @(negedge clk); n_cmp++;
      if (obs !== exp_obs) begin n_err++; $display("FAIL random c=%0d act=%h exp=%h", c, obs, exp_obs); end
      for (int p = 0; p < 2; p++) if (m_g == p) busy[p] = 1'b0;
      next_edge();
    end
    idle(); model_eval();
    @(negedge clk); n_cmp++;
    if (obs !== exp_obs) begin n_err++; $display("FAIL random_drain act=%h exp=%h", obs, exp_obs); end
    next_edge();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < 8; i++) begin ram[i] = pre(i); ref_mem[i] = pre(i); end
    ram[16] = 32'hA5A5_0010; ref_mem[16] = 32'hA5A5_0010;
    test_reset();
    test_tie_read();
    test_write_be();
    test_fairness();
    test_back_to_back();
    test_reset_mid_read();
    test_rw_both();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
